// File: rtl/serial_word_tx_if.sv
// Handshake and serial-line bundle for serial_word_tx.
//   din      parallel word offered by the producer
//   load     word-valid request from the producer
//   ready    transmitter can take a word this cycle
//   x        serial bit stream toward the sequence recognizer
//   x_valid  x carries a data (or parity) bit
//   done     final bit of the current word is on x
// master: word producer / line observer.  slave: the transmitter.
interface serial_word_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             x;
    logic             x_valid;
    logic             done;

    modport master (
        output din, load,
        input  ready, x, x_valid, done
    );

    modport slave (
        input  din, load,
        output ready, x, x_valid, done
    );
endinterface

// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial stage feeding a bit-level recognizer.
// Accepts WIDTH-bit words on a valid/ready handshake and shifts them out one
// bit per clock on bus.x; back-to-back words leave no gap on the line.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    serial_word_tx_if.slave (din, load, ready, x, x_valid, done)
//
// Parameters:
//   WIDTH      data word width, 2..32
//   MSB_FIRST  1: din[WIDTH-1] goes out first; 0: din[0] goes out first
//
// Optional feature macro: SERIAL_WORD_TX_PARITY_EN
//   When defined, an even-parity bit (XOR of the captured word) follows the
//   data bits and done/ready move to that cycle.
//
// state | meaning
// IDLE  | line quiet, waiting for a word
// SHIFT | one frame bit on x per cycle, cnt = index of the bit on x
module serial_word_tx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    serial_word_tx_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef SERIAL_WORD_TX_PARITY_EN
    localparam int L = WIDTH + 1;
`else
    localparam int L = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             last;
    logic             accept;
    logic             data_bit;

`ifdef SERIAL_WORD_TX_PARITY_EN
    logic par, par_nxt;
`endif

    // The last-bit cycle doubles as an accept slot so the next word follows
    // without an idle gap.
    assign last     = (state == SHIFT) && (cnt == LAST);
    assign accept   = bus.load && bus.ready;
    assign data_bit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
`ifdef SERIAL_WORD_TX_PARITY_EN
            par   <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        cnt_nxt     = cnt;
`ifdef SERIAL_WORD_TX_PARITY_EN
        par_nxt     = par;
`endif
        bus.ready   = (state == IDLE) || last;
        bus.x       = 1'b0;
        bus.x_valid = 1'b0;
        bus.done    = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    shreg_nxt = bus.din;
                    cnt_nxt   = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
                    par_nxt   = ^bus.din;
`endif
                end
            end
            SHIFT: begin
                bus.x_valid = 1'b1;
                bus.x       = data_bit;
`ifdef SERIAL_WORD_TX_PARITY_EN
                // Data bits are exhausted; the extra cycle carries parity.
                if (cnt == CW'(WIDTH)) begin
                    bus.x = par;
                end
`endif
                bus.done = last;
                if (last) begin
                    cnt_nxt = '0;
                    if (accept) begin
                        shreg_nxt = bus.din;
`ifdef SERIAL_WORD_TX_PARITY_EN
                        par_nxt   = ^bus.din;
`endif
                    end else begin
                        state_nxt = IDLE;
                        shreg_nxt = '0;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                    if (MSB_FIRST != 0) begin
                        shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
